// File: rtl/gem_rate_pkg.sv
// Shared constants for the GEM front-panel rate meter: decade thresholds for
// the logarithmic LED bar, the default rate width and a constant-safe clog2.
package gem_rate_pkg;

  localparam int RATE_WIDTH = 32;

  // Decade thresholds 10^0 .. 10^9; bar bit k lights when rate >= DECADE_THRESH[k].
  localparam logic [31:0] DECADE_THRESH [0:9] = '{
    32'd1,
    32'd10,
    32'd100,
    32'd1000,
    32'd10000,
    32'd100000,
    32'd1000000,
    32'd10000000,
    32'd100000000,
    32'd1000000000
  };

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input longint unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rate_bar_encoder.sv
// Registered thermometer encoder: compares the published rate against BAR_WIDTH
// thresholds (decades or linear steps) and loads the bar when load_i pulses.
// valid_o is a one-cycle pulse that coincides with the bar taking its new value.
module rate_bar_encoder
  import gem_rate_pkg::*;
#(
  parameter int RATE_W      = RATE_WIDTH,
  parameter int BAR_WIDTH   = 8,
  parameter int LOGARITHMIC = 1,
  parameter int BAR_STEP    = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [RATE_W-1:0]    rate_i,
  input  logic                 load_i,
  output logic [BAR_WIDTH-1:0] bar_o,
  output logic                 valid_o
);

  logic [63:0]          rate_ext;
  logic [BAR_WIDTH-1:0] hit;
  logic [BAR_WIDTH-1:0] bar_q;
  logic                 valid_q;

  assign rate_ext = 64'(rate_i);

  // One unsigned compare per LED; thresholds are increasing so the result is a thermometer.
  for (genvar k = 0; k < BAR_WIDTH; k++) begin : g_bit
    if (LOGARITHMIC != 0) begin : g_log
      if (k < 10) begin : g_dec
        localparam logic [63:0] THR = 64'(DECADE_THRESH[k]);
        assign hit[k] = (rate_ext >= THR);
      end else begin : g_none
        assign hit[k] = 1'b0;
      end
    end else begin : g_lin
      localparam logic [63:0] THR = 64'(k + 1) * 64'(BAR_STEP);
      assign hit[k] = (rate_ext >= THR);
    end
  end

  // Bar only moves on a load, and the valid pulse marks exactly that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      bar_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_i;
      if (load_i) bar_q <= hit;
    end
  end

  assign bar_o   = bar_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cluster_rate_meter.sv
// Gated-window cluster rate meter. Sums increment_i over WINDOW cycles, publishes
// the window sum scaled to Hz (saturating) one cycle after the terminal cycle and
// hands it to the bar encoder, whose output lands one cycle later.
module cluster_rate_meter
  import gem_rate_pkg::*;
#(
  parameter int CLK_FREQUENCY   = 40079000,
  parameter int SPEEDUP_SHIFT   = 4,
  parameter int COUNTER_WIDTH   = RATE_WIDTH,
  parameter int INCREMENT_WIDTH = 8,
  parameter int BAR_WIDTH       = 8,
  parameter int LOGARITHMIC     = 1,
  parameter int BAR_STEP        = 100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [INCREMENT_WIDTH-1:0] increment_i,
  output logic [COUNTER_WIDTH-1:0]   rate_o,
  output logic [BAR_WIDTH-1:0]       progress_bar_o,
  output logic                       rate_valid_o,
  output logic                       saturated_o
);

  localparam int WINDOW = CLK_FREQUENCY >> SPEEDUP_SHIFT;
  localparam int CNT_W  = (clog2(longint'(WINDOW)) < 1) ? 1 : clog2(longint'(WINDOW));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  if (WINDOW < 2) begin : g_bad_window
    $error("cluster_rate_meter: window must be at least 2 cycles");
  end

  logic [CNT_W-1:0]         count_q, count_d;
  logic [COUNTER_WIDTH-1:0] acc_q, acc_d;
  logic                     acc_sat_q, acc_sat_d;
  logic [COUNTER_WIDTH-1:0] rate_q, rate_d;
  logic                     sat_q, sat_d;
  logic                     pub_q, pub_d;

  logic                     terminal;
  logic [COUNTER_WIDTH:0]   sum_ext;
  logic                     overflow;
  logic [COUNTER_WIDTH-1:0] sum_sat;
  logic [COUNTER_WIDTH-1:0] rate_shift;
  logic                     clip;

  // Window counter, saturating accumulator and the scale/clip of the closing sum.
  // The terminal cycle's increment is folded into the closing sum, and the next
  // window restarts from zero so no cycle is lost or counted twice.
  always_comb begin
    terminal   = (count_q == LAST);
    sum_ext    = {1'b0, acc_q} + (COUNTER_WIDTH + 1)'(increment_i);
    overflow   = sum_ext[COUNTER_WIDTH];
    sum_sat    = overflow ? '1 : sum_ext[COUNTER_WIDTH-1:0];
    rate_shift = sum_sat << SPEEDUP_SHIFT;
    clip       = overflow | acc_sat_q | ((sum_sat >> (COUNTER_WIDTH - SPEEDUP_SHIFT)) != '0);

    count_d   = terminal ? '0 : count_q + 1'b1;
    acc_d     = terminal ? '0 : sum_sat;
    acc_sat_d = terminal ? 1'b0 : (acc_sat_q | overflow);
    rate_d    = rate_q;
    sat_d     = sat_q;
    pub_d     = terminal;
    if (terminal) begin
      rate_d = clip ? '1 : rate_shift;
      sat_d  = clip;
    end
  end

  // State registers; reset discards any partial window.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      rate_q    <= '0;
      sat_q     <= 1'b0;
      pub_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      rate_q    <= rate_d;
      sat_q     <= sat_d;
      pub_q     <= pub_d;
    end
  end

  rate_bar_encoder #(
    .RATE_W      (COUNTER_WIDTH),
    .BAR_WIDTH   (BAR_WIDTH),
    .LOGARITHMIC (LOGARITHMIC),
    .BAR_STEP    (BAR_STEP)
  ) u_bar (
    .clock   (clock),
    .reset   (reset),
    .rate_i  (rate_q),
    .load_i  (pub_q),
    .bar_o   (progress_bar_o),
    .valid_o (rate_valid_o)
  );

  assign rate_o      = rate_q;
  assign saturated_o = sat_q;

endmodule

// File: tb/tb_cluster_rate_meter.sv
// Directed bench for cluster_rate_meter: three instances (log, 16-bit saturating,
// linear) share clock and reset; each scenario task checks its own outputs.
module tb_cluster_rate_meter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inc_a = '0;
  logic [7:0]  inc_b = '0;

  logic [31:0] m_rate;
  logic [7:0]  m_bar;
  logic        m_valid, m_sat;
  logic [15:0] s_rate;
  logic [7:0]  s_bar;
  logic        s_valid, s_sat;
  logic [31:0] l_rate;
  logic [7:0]  l_bar;
  logic        l_valid, l_sat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  cluster_rate_meter #(
    .CLK_FREQUENCY(160), .SPEEDUP_SHIFT(4), .COUNTER_WIDTH(32), .INCREMENT_WIDTH(8),
    .BAR_WIDTH(8), .LOGARITHMIC(1), .BAR_STEP(100)
  ) u_main (
    .clock(clock), .reset(reset), .increment_i(inc_a), .rate_o(m_rate),
    .progress_bar_o(m_bar), .rate_valid_o(m_valid), .saturated_o(m_sat)
  );

  cluster_rate_meter #(
    .CLK_FREQUENCY(16000), .SPEEDUP_SHIFT(4), .COUNTER_WIDTH(16), .INCREMENT_WIDTH(8),
    .BAR_WIDTH(8), .LOGARITHMIC(1), .BAR_STEP(100)
  ) u_sat (
    .clock(clock), .reset(reset), .increment_i(inc_b), .rate_o(s_rate),
    .progress_bar_o(s_bar), .rate_valid_o(s_valid), .saturated_o(s_sat)
  );

  cluster_rate_meter #(
    .CLK_FREQUENCY(160), .SPEEDUP_SHIFT(4), .COUNTER_WIDTH(32), .INCREMENT_WIDTH(8),
    .BAR_WIDTH(8), .LOGARITHMIC(0), .BAR_STEP(100)
  ) u_lin (
    .clock(clock), .reset(reset), .increment_i(inc_a), .rate_o(l_rate),
    .progress_bar_o(l_bar), .rate_valid_o(l_valid), .saturated_o(l_sat)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench in cycle 0 of a fresh window with reset low.
  task automatic do_reset();
    reset = 1'b1;
    inc_a = '0;
    inc_b = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (m_rate !== 32'd0 || m_bar !== 8'd0 || m_valid !== 1'b0 || m_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_main: rate=%0d bar=%b valid=%b sat=%b, want all 0", m_rate, m_bar, m_valid, m_sat);
    end
    vectors++;
    if (s_rate !== 16'd0 || s_bar !== 8'd0 || s_valid !== 1'b0 || s_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sat: rate=%0d bar=%b valid=%b sat=%b, want all 0", s_rate, s_bar, s_valid, s_sat);
    end
  endtask

  task automatic test_unit_rate();
    int pulses;
    do_reset();
    inc_a = 8'd1;
    ticks(10);
    vectors++;
    if (m_rate !== 32'd160 || m_valid !== 1'b0 || m_bar !== 8'd0) begin
      miscompares++;
      $display("FAIL unit_t1: rate=%0d valid=%b bar=%b, want 160/0/00000000", m_rate, m_valid, m_bar);
    end
    tick();
    vectors++;
    if (m_bar !== 8'b0000_0111 || m_valid !== 1'b1 || m_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL unit_t2: bar=%b valid=%b sat=%b, want 00000111/1/0", m_bar, m_valid, m_sat);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 2 || m_rate !== 32'd160 || m_bar !== 8'b0000_0111) begin
      miscompares++;
      $display("FAIL unit_steady: pulses=%0d rate=%0d bar=%b, want 2/160/00000111", pulses, m_rate, m_bar);
    end
  endtask

  task automatic test_full_scale();
    do_reset();
    inc_a = 8'd255;
    ticks(10);
    inc_a = 8'd0;
    vectors++;
    if (m_rate !== 32'd40800 || m_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rate: rate=%0d sat=%b, want 40800/0", m_rate, m_sat);
    end
    tick();
    vectors++;
    if (m_bar !== 8'b0001_1111 || m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_bar: bar=%b valid=%b, want 00011111/1", m_bar, m_valid);
    end
    ticks(9);
    vectors++;
    if (m_rate !== 32'd0 || m_bar !== 8'b0001_1111) begin
      miscompares++;
      $display("FAIL zero_rate: rate=%0d bar=%b, want 0/00011111", m_rate, m_bar);
    end
    tick();
    vectors++;
    if (m_bar !== 8'd0 || m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_bar: bar=%b valid=%b, want 00000000/1", m_bar, m_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    inc_b = 8'd255;
    ticks(1000);
    vectors++;
    if (s_rate !== 16'hFFFF || s_sat !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_rate: rate=%h sat=%b, want ffff/1", s_rate, s_sat);
    end
    tick();
    vectors++;
    if (s_bar !== 8'b0001_1111 || s_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_bar: bar=%b valid=%b, want 00011111/1", s_bar, s_valid);
    end
    inc_b = 8'd0;
  endtask

  task automatic test_window_edge();
    do_reset();
    ticks(9);
    inc_a = 8'd1;
    tick();
    vectors++;
    if (m_rate !== 32'd16) begin
      miscompares++;
      $display("FAIL edge_terminal: rate=%0d, want 16", m_rate);
    end
    tick();
    inc_a = 8'd0;
    ticks(9);
    vectors++;
    if (m_rate !== 32'd16) begin
      miscompares++;
      $display("FAIL edge_first: rate=%0d, want 16", m_rate);
    end
    tick();
    vectors++;
    if (m_bar !== 8'b0000_0011 || m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_bar: bar=%b valid=%b, want 00000011/1", m_bar, m_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    inc_a = 8'd1;
    ticks(15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (m_rate !== 32'd0 || m_bar !== 8'd0 || m_valid !== 1'b0 || m_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_out: rate=%0d bar=%b valid=%b sat=%b, want all 0", m_rate, m_bar, m_valid, m_sat);
    end
    ticks(10);
    vectors++;
    if (m_rate !== 32'd160) begin
      miscompares++;
      $display("FAIL midreset_rate: rate=%0d, want 160", m_rate);
    end
  endtask

  task automatic test_linear();
    do_reset();
    inc_a = 8'd1;
    ticks(10);
    inc_a = 8'd5;
    vectors++;
    if (l_rate !== 32'd160) begin
      miscompares++;
      $display("FAIL lin_rate160: rate=%0d, want 160", l_rate);
    end
    tick();
    vectors++;
    if (l_bar !== 8'b0000_0001 || l_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lin_bar160: bar=%b valid=%b, want 00000001/1", l_bar, l_valid);
    end
    ticks(9);
    vectors++;
    if (l_rate !== 32'd800) begin
      miscompares++;
      $display("FAIL lin_rate800: rate=%0d, want 800", l_rate);
    end
    tick();
    vectors++;
    if (l_bar !== 8'b1111_1111 || l_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lin_bar800: bar=%b valid=%b, want 11111111/1", l_bar, l_valid);
    end
    inc_a = 8'd0;
  endtask

  initial begin
    test_reset();
    test_unit_rate();
    test_full_scale();
    test_saturation();
    test_window_edge();
    test_mid_reset();
    test_linear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
